// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer for a ROWS x COLS occupancy map: scans bottom-up, removes
// full rows by shifting everything above down one row, then blanks row 0.
module line_clear_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [AW-1:0]   row_rd_addr,
  input  logic [COLS-1:0] row_rd_data,
  output logic            row_wr_en,
  output logic [AW-1:0]   row_wr_addr,
  output logic [COLS-1:0] row_wr_data,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   lines_cleared,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_SHIFT = 3'd2,
    S_CLR   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_e        state_q;
  logic [AW-1:0] r_q;
  logic [AW-1:0] s_q;
  logic [CW-1:0] lc_q;
  logic          row_full;

  assign row_full = (row_rd_data == '1);

  // Handshake: start is a request taken only in IDLE (no queuing); the pass
  // acknowledges with a single-cycle done, and busy covers SCAN/SHIFT/CLR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= LAST_ROW;
      s_q     <= '0;
      lc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SCAN;
            r_q     <= LAST_ROW;
            lc_q    <= '0;
          end
        end
        S_SCAN: begin
          if (row_full) begin
            lc_q    <= lc_q + CW'(1);
            s_q     <= r_q;
            // A full top row has nothing above it to copy down.
            state_q <= (r_q == '0) ? S_CLR : S_SHIFT;
          end else if (r_q == '0) begin
            state_q <= S_DONE;
          end else begin
            r_q <= r_q - AW'(1);
          end
        end
        S_SHIFT: begin
          if (s_q == AW'(1)) begin
            state_q <= S_CLR;
          end else begin
            s_q <= s_q - AW'(1);
          end
        end
        S_CLR:   state_q <= S_SCAN;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    row_rd_addr = r_q;
    row_wr_en   = 1'b0;
    row_wr_addr = s_q;
    row_wr_data = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_SCAN: busy = 1'b1;
      S_SHIFT: begin
        busy        = 1'b1;
        row_rd_addr = s_q - AW'(1);
        row_wr_en   = 1'b1;
        row_wr_addr = s_q;
        row_wr_data = row_rd_data;
      end
      S_CLR: begin
        busy        = 1'b1;
        row_wr_en   = 1'b1;
        row_wr_addr = '0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign lines_cleared = lc_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: a map store around the DUT, an array-level model of
// the pass result and timing, and per-cycle checks of busy/done/write strobes.
module tb_line_clear_ctrl;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [COLS-1:0] map_t [ROWS];

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [COLS-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [3:0]      lc;
  logic [2:0]      dbg_state;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .row_rd_addr   (rd_addr),
    .row_rd_data   (rd_data),
    .row_wr_en     (wr_en),
    .row_wr_addr   (wr_addr),
    .row_wr_data   (wr_data),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lc),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- map store (read-before-write, write on clk edge)
  map_t mem;
  map_t load_map;
  logic load_en;
  int   wr_count = 0;

  assign rd_data = mem[rd_addr];

  always @(posedge clk) begin
    if (load_en) begin
      mem <= load_map;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
    end
  end

  // ---------------- scoreboard state
  int              checks = 0;
  int              errors = 0;
  int              busy_left = 0;
  bit              done_due = 1'b0;
  int              exp_lc = 0;
  logic [COLS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a pass from the rules: full rows vanish, others keep order and sink,
  // the top fills with zeros. A full row found at position p costs p+2 cycles and
  // p+1 writes; every position is also scanned once while holding a non-full row.
  function automatic void model(input map_t m, output map_t f, output int n_lc,
                                output int n_busy, output int n_wr);
    int k;
    int pos;
    k      = ROWS - 1;
    n_lc   = 0;
    n_busy = ROWS;
    n_wr   = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (m[i] == '1) begin
        pos    = i + n_lc;
        n_busy += pos + 2;
        n_wr   += pos + 1;
        n_lc++;
      end else begin
        f[k] = m[i];
        k--;
      end
    end
    for (int i = 0; i <= k; i++) f[i] = '0;
  endfunction

  // One clock of per-cycle output checking, sampled at the falling edge.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      check("busy", 32'(busy), 32'(busy_left > 0));
      check("done", 32'(done), 32'(busy_left == 0 && done_due));
      if (busy_left == 0) begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
        check("lines_cleared", 32'(lc), 32'(exp_lc));
      end
      if (busy_left > 0) busy_left--;
      else done_due = 1'b0;
    end
  endtask

  task automatic load(input map_t m);
    load_map = m;
    load_en  = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic run_pass(input bit rep_en);
    map_t cur;
    map_t f;
    int   m_lc, m_n, m_w, wc0, rep;
    cur = mem;
    model(cur, f, m_lc, m_n, m_w);
    for (int i = 0; i < ROWS; i++) exp_q.push_back(f[i]);
    wc0 = wr_count;
    rep = rep_en ? $urandom_range(1, m_n) : 0;
    start = 1'b1;
    @(posedge clk);
    busy_left = m_n;
    done_due  = 1'b1;
    exp_lc    = m_lc;
    #1 start = 1'b0;
    for (int k = 1; k <= m_n + 2; k++) begin
      step();
      start = (k == rep);
    end
    start = 1'b0;
    for (int i = 0; i < ROWS; i++) check($sformatf("row%0d", i), 32'(mem[i]), 32'(exp_q.pop_front()));
    check("write_count", 32'(wr_count - wc0), 32'(m_w));
  endtask

  task automatic pin(input string name, input map_t m, input map_t lit_f,
                     input int lit_lc, input int lit_n);
    map_t f;
    int   m_lc, m_n, m_w;
    model(m, f, m_lc, m_n, m_w);
    check({name, "_lc"}, 32'(m_lc), 32'(lit_lc));
    check({name, "_cycles"}, 32'(m_n), 32'(lit_n));
    for (int i = 0; i < ROWS; i++) check($sformatf("%s_row%0d", name, i), 32'(f[i]), 32'(lit_f[i]));
  endtask

  initial begin
    map_t m_empty, m_031, f_031, m_032, f_032, m_full, m_part, m_rnd;
    logic [COLS-1:0] v;

    m_empty = '{default: 8'h00};
    m_full  = '{default: 8'hFF};
    m_031   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h81, 8'hFF};
    f_031   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h81};
    m_032   = '{8'h10, 8'h11, 8'hFF, 8'h13, 8'h14, 8'hFF, 8'h16, 8'h17};
    f_032   = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h13, 8'h14, 8'h16, 8'h17};

    reset   = 1'b1;
    start   = 1'b0;
    load_en = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_lc", 32'(lc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Hand-computed results pinning the model.
    pin("pin_empty", m_empty, m_empty, 0, 8);
    pin("pin_031", m_031, f_031, 1, 17);
    pin("pin_032", m_032, f_032, 2, 20);
    pin("pin_full", m_full, m_empty, 8, 80);

    load(m_empty); run_pass(1'b0);
    load(m_031);   run_pass(1'b0);
    load(m_032);   run_pass(1'b0);
    load(m_full);  run_pass(1'b0);

    // start re-pulsed while busy must not restart the pass.
    load(m_031);   run_pass(1'b1);
    load(m_full);  run_pass(1'b1);

    // Reset in the second SHIFT cycle: only row7 <= row6 has been written.
    load(m_031);
    start = 1'b1;
    @(posedge clk);
    busy_left = 17;
    done_due  = 1'b1;
    exp_lc    = 1;
    #1 start = 1'b0;
    step(); step(); step();
    check("wr_en_in_shift", 32'(wr_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_lc", 32'(lc), 32'd0);
    busy_left = 0;
    done_due  = 1'b0;
    exp_lc    = 0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_part = m_031;
    m_part[7] = 8'h81;
    for (int i = 0; i < ROWS; i++) check($sformatf("abort_row%0d", i), 32'(mem[i]), 32'(m_part[i]));
    run_pass(1'b0);

    // Randomized maps, roughly one row in three full.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < ROWS; i++) begin
        v = COLS'($urandom);
        if (v == '1) v = 8'hFE;
        m_rnd[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : v;
      end
      load(m_rnd);
      run_pass(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
